// File: rtl/controller_reduce_seq_pkg.sv
// Shared types for the calculator operator-reduction sequencer:
// operator codes, data/operator widths and sequencer state encoding.
package controller_reduce_seq_pkg;
  localparam int CO_N = 3;
  localparam int CD_N = 16;

  typedef logic [CO_N-1:0] co_t;
  typedef logic [CD_N-1:0] cd_t;

  localparam co_t CO_NO  = 3'd0;
  localparam co_t CO_ADD = 3'd1;
  localparam co_t CO_SUB = 3'd2;
  localparam co_t CO_MUL = 3'd3;
  localparam co_t CO_DIV = 3'd4;

  typedef enum logic [3:0] {
    CR_IDLE,
    CR_CHECK,
    CR_POP_B,
    CR_POP_A,
    CR_EXEC,
    CR_PUSH_R,
    CR_PUSH_OP,
    CR_DONE,
    CR_ERR
  } cr_state_e;

  // CO_NO submitted as an operator means "flush": reduce until the op stack is empty.
  function automatic logic is_flush(co_t op);
    return op == CO_NO;
  endfunction
endpackage

// File: rtl/controller_reduce_seq_if.sv
// Command, stack, ALU and precedence-ROM signals of the reduction sequencer.
// master = sequencer side, slave = controller/stack/ALU environment side.
interface controller_reduce_seq_if;
  import controller_reduce_seq_pkg::*;

  logic start;
  co_t  op_in;
  logic busy;
  logic done;
  logic err;
  cd_t  dt_data;
  logic dt_empty;
  logic dt_pop;
  logic dt_push;
  cd_t  dt_wdata;
  co_t  op_data;
  logic op_empty;
  logic op_pop;
  logic op_push;
  co_t  op_wdata;
  co_t  pr_a;
  co_t  pr_b;
  logic pr_res;
  cd_t  al_A;
  cd_t  al_B;
  co_t  al_op;
  cd_t  al_C;

  modport master (
    input  start, op_in, dt_data, dt_empty, op_data, op_empty, pr_res, al_C,
    output busy, done, err, dt_pop, dt_push, dt_wdata, op_pop, op_push, op_wdata,
           pr_a, pr_b, al_A, al_B, al_op
  );

  modport slave (
    output start, op_in, dt_data, dt_empty, op_data, op_empty, pr_res, al_C,
    input  busy, done, err, dt_pop, dt_push, dt_wdata, op_pop, op_push, op_wdata,
           pr_a, pr_b, al_A, al_B, al_op
  );
endinterface

// File: rtl/controller_reduce_seq.sv
// Operator-reduction sequencer: reduces the op/data stacks by precedence, then pushes the new op.
// Optional stack-underflow detection is enabled with `define REDUCE_UNDERFLOW_EN.
module controller_reduce_seq
  import controller_reduce_seq_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input logic                    Clock,
  input logic                    Reset,
  controller_reduce_seq_if.master cr
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

`ifdef REDUCE_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  cr_state_e        state_q, state_d;
  co_t              cur_op_q, cur_op_d;
  co_t              al_op_q, al_op_d;
  cd_t              al_a_q, al_a_d;
  cd_t              al_b_q, al_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic underflow;
  logic reduce_req;

  assign underflow  = UF_EN && cr.dt_empty;
  assign reduce_req = is_flush(cur_op_q) || cr.pr_res;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= CR_IDLE;
      cur_op_q <= CO_NO;
      al_op_q  <= CO_NO;
      al_a_q   <= '0;
      al_b_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_op_q <= cur_op_d;
      al_op_q  <= al_op_d;
      al_a_q   <= al_a_d;
      al_b_q   <= al_b_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_op_d = cur_op_q;
    al_op_d  = al_op_q;
    al_a_d   = al_a_q;
    al_b_d   = al_b_q;
    cnt_d    = cnt_q;
    case (state_q)
      CR_IDLE: begin
        if (cr.start) begin
          cur_op_d = cr.op_in;
          state_d  = CR_CHECK;
        end
      end
      CR_CHECK: begin
        if (cr.op_empty) begin
          state_d = is_flush(cur_op_q) ? CR_DONE : CR_PUSH_OP;
        end else if (reduce_req) begin
          if (underflow) begin
            state_d = CR_ERR;
          end else begin
            al_op_d = cr.op_data;
            state_d = CR_POP_B;
          end
        end else begin
          state_d = CR_PUSH_OP;
        end
      end
      CR_POP_B: begin
        if (underflow) begin
          state_d = CR_ERR;
        end else begin
          al_b_d  = cr.dt_data;
          state_d = CR_POP_A;
        end
      end
      CR_POP_A: begin
        if (underflow) begin
          state_d = CR_ERR;
        end else begin
          al_a_d  = cr.dt_data;
          cnt_d   = '0;
          state_d = CR_EXEC;
        end
      end
      CR_EXEC: begin
        if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
          state_d = CR_PUSH_R;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CR_PUSH_R:  state_d = CR_CHECK;
      CR_PUSH_OP: state_d = CR_DONE;
      CR_DONE:    state_d = CR_IDLE;
      CR_ERR:     state_d = CR_ERR;
      default:    state_d = CR_IDLE;
    endcase
  end

  // Strobes decode the current state; the CHECK pop also qualifies on the reduce decision.
  assign cr.busy     = (state_q != CR_IDLE);
  assign cr.done     = (state_q == CR_DONE);
  assign cr.op_pop   = (state_q == CR_CHECK) && !cr.op_empty && reduce_req && !underflow;
  assign cr.dt_pop   = ((state_q == CR_POP_B) || (state_q == CR_POP_A)) && !underflow;
  assign cr.dt_push  = (state_q == CR_PUSH_R);
  assign cr.dt_wdata = (state_q == CR_PUSH_R) ? cr.al_C : '0;
  assign cr.op_push  = (state_q == CR_PUSH_OP);
  assign cr.op_wdata = (state_q == CR_PUSH_OP) ? cur_op_q : CO_NO;
  assign cr.pr_a     = cr.op_data;
  assign cr.pr_b     = cur_op_q;
  assign cr.al_A     = al_a_q;
  assign cr.al_B     = al_b_q;
  assign cr.al_op    = al_op_q;

`ifdef REDUCE_UNDERFLOW_EN
  assign cr.err = (state_q == CR_ERR);
`else
  assign cr.err = 1'b0;
`endif

endmodule

// File: tb/tb_controller_reduce_seq.sv
// Directed bench for controller_reduce_seq with queue-based stack models and a 3-cycle ALU pipe.
module tb_controller_reduce_seq;
  import controller_reduce_seq_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  controller_reduce_seq_if cr();

  controller_reduce_seq #(.ALU_LAT(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .cr    (cr)
  );

  cd_t  dt_m[$];
  co_t  op_m[$];
  cd_t  load_dt[$];
  co_t  load_op[$];
  logic load_req = 1'b0;
  int   op_push_n = 0;
  int   dt_pop_n = 0;
  cd_t  alu_s [3];
  int   total = 0;
  int   bad = 0;

  function automatic cd_t alu(co_t op, cd_t a, cd_t b);
    case (op)
      CO_ADD:  return a + b;
      CO_SUB:  return a - b;
      CO_MUL:  return a * b;
      CO_DIV:  return (b != 0) ? a / b : '0;
      default: return '0;
    endcase
  endfunction

  // Stack strobes take effect at the edge; stack tops are visible the following cycle.
  always @(posedge Clock) begin
    if (load_req) begin
      dt_m.delete();
      op_m.delete();
      foreach (load_dt[i]) dt_m.push_back(load_dt[i]);
      foreach (load_op[i]) op_m.push_back(load_op[i]);
    end else begin
      if (cr.dt_pop) begin
        dt_pop_n <= dt_pop_n + 1;
        if (dt_m.size() > 0) void'(dt_m.pop_back());
      end
      if (cr.dt_push) dt_m.push_back(cr.dt_wdata);
      if (cr.op_pop && op_m.size() > 0) void'(op_m.pop_back());
      if (cr.op_push) begin
        op_push_n <= op_push_n + 1;
        op_m.push_back(cr.op_wdata);
      end
    end
    alu_s[0]    <= alu(cr.al_op, cr.al_A, cr.al_B);
    alu_s[1]    <= alu_s[0];
    alu_s[2]    <= alu_s[1];
    cr.dt_data  <= (dt_m.size() > 0) ? dt_m[$] : '0;
    cr.dt_empty <= (dt_m.size() == 0);
    cr.op_data  <= (op_m.size() > 0) ? op_m[$] : CO_NO;
    cr.op_empty <= (op_m.size() == 0);
  end
  assign cr.al_C = alu_s[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load();
    load_req = 1'b1;
    @(negedge Clock);
    load_req = 1'b0;
  endtask

  // Submits op, reports start->done latency; poke re-asserts start mid-operation.
  task automatic run(input co_t op, input logic pr, input int exp_cyc, input logic poke,
                     input string tag);
    int cyc;
    cr.op_in  = op;
    cr.pr_res = pr;
    cr.start  = 1'b1;
    @(negedge Clock);
    cr.start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, cr.busy, 1);
    while (!cr.done && cyc < 60) begin
      cr.start = poke && (cyc == 2);
      @(negedge Clock);
      cyc++;
    end
    cr.start = 1'b0;
    chk({tag, "_cycles"}, cyc, exp_cyc);
    $display("txn %s op=%0d start->done=%0d cycles dt_depth=%0d op_depth=%0d",
             tag, op, cyc, dt_m.size(), op_m.size());
    @(negedge Clock);
    chk({tag, "_idle_busy"}, cr.busy, 0);
    chk({tag, "_idle_done"}, cr.done, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, cr.busy, 0);
    chk({tag, "_done"}, cr.done, 0);
    chk({tag, "_err"}, cr.err, 0);
    chk({tag, "_strobes"}, {cr.dt_pop, cr.dt_push, cr.op_pop, cr.op_push}, 0);
    chk({tag, "_al_A"}, cr.al_A, 0);
    chk({tag, "_al_B"}, cr.al_B, 0);
    chk({tag, "_al_op"}, cr.al_op, CO_NO);
    chk({tag, "_dt_wdata"}, cr.dt_wdata, 0);
    chk({tag, "_op_wdata"}, cr.op_wdata, CO_NO);
    chk({tag, "_pr_b"}, cr.pr_b, CO_NO);
  endtask

  initial begin
    int push0;
    int pop0;
    cr.start  = 1'b0;
    cr.op_in  = CO_NO;
    cr.pr_res = 1'b0;
    repeat (2) @(negedge Clock);
    chk_reset_outputs("rst");
    Reset = 1'b1;

    // No reduction: MUL onto [ADD]
    load_dt = '{16'd2, 16'd3};
    load_op = '{CO_ADD};
    do_load();
    run(CO_MUL, 1'b0, 3, 1'b0, "push");
    chk("push_op_depth", op_m.size(), 2);
    chk("push_op_top", op_m[1], CO_MUL);
    chk("push_dt_depth", dt_m.size(), 2);
    chk("push_dt_top", dt_m[1], 3);
    chk("push_pr_a", cr.pr_a, CO_MUL);
    chk("push_pr_b", cr.pr_b, CO_MUL);

    // Two reductions: 3*4=12, 2+12=14; a start pulse mid-run must be ignored
    load_dt = '{16'd2, 16'd3, 16'd4};
    load_op = '{CO_ADD, CO_MUL};
    do_load();
    push0 = op_push_n;
    pop0  = dt_pop_n;
    run(CO_ADD, 1'b1, 17, 1'b1, "reduce2");
    chk("reduce2_dt_depth", dt_m.size(), 1);
    chk("reduce2_dt_val", dt_m[0], 14);
    chk("reduce2_op_depth", op_m.size(), 1);
    chk("reduce2_op_val", op_m[0], CO_ADD);
    chk("reduce2_op_pushes", op_push_n - push0, 1);
    chk("reduce2_dt_pops", dt_pop_n - pop0, 4);

    // Flush, operand order: 10-3
    load_dt = '{16'd10, 16'd3};
    load_op = '{CO_SUB};
    do_load();
    push0 = op_push_n;
    run(CO_NO, 1'b0, 9, 1'b0, "flush");
    chk("flush_dt_depth", dt_m.size(), 1);
    chk("flush_dt_val", dt_m[0], 7);
    chk("flush_op_depth", op_m.size(), 0);
    chk("flush_op_pushes", op_push_n - push0, 0);

    // One reduction with ALU_LAT=3: 6*4=24 then push SUB, 3+4+3 = 10 cycles
    load_dt = '{16'd6, 16'd4};
    load_op = '{CO_MUL};
    do_load();
    run(CO_SUB, 1'b1, 10, 1'b0, "alu_lat");
    chk("alu_lat_dt_val", dt_m[0], 24);
    chk("alu_lat_op_top", op_m[0], CO_SUB);

    // Underflow: one operand for a binary op
    load_dt = '{16'd5};
    load_op = '{CO_ADD};
    do_load();
`ifdef REDUCE_UNDERFLOW_EN
    pop0 = dt_pop_n;
    cr.op_in = CO_NO;
    cr.start = 1'b1;
    @(negedge Clock);
    cr.start = 1'b0;
    repeat (4) @(negedge Clock);
    chk("uf_err", cr.err, 1);
    chk("uf_busy", cr.busy, 1);
    chk("uf_dt_pops", dt_pop_n - pop0, 1);
    cr.start = 1'b1;
    @(negedge Clock);
    cr.start = 1'b0;
    @(negedge Clock);
    chk("uf_err_sticky", cr.err, 1);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
`else
    run(CO_NO, 1'b0, 9, 1'b0, "uf_off");
    chk("uf_off_err", cr.err, 0);
    chk("uf_off_dt_val", dt_m[0], 5);
`endif

    // Reset while in EXEC aborts the reduction
    load_dt = '{16'd6, 16'd4};
    load_op = '{CO_MUL};
    do_load();
    cr.op_in  = CO_SUB;
    cr.pr_res = 1'b1;
    cr.start  = 1'b1;
    @(negedge Clock);
    cr.start = 1'b0;
    repeat (3) @(negedge Clock);
    chk("exec_al_A", cr.al_A, 6);
    chk("exec_al_B", cr.al_B, 4);
    chk("exec_al_op", cr.al_op, CO_MUL);
    Reset = 1'b0;
    @(negedge Clock);
    chk_reset_outputs("rst_exec");
    $display("txn reset_in_exec busy=%0d al_A=%0d", cr.busy, cr.al_A);
    Reset = 1'b1;

    // Empty op stack after reset: plain push
    load_dt = '{16'd1};
    load_op.delete();
    do_load();
    run(CO_ADD, 1'b0, 3, 1'b0, "post_rst");
    chk("post_rst_op_depth", op_m.size(), 1);
    chk("post_rst_op_val", op_m[0], CO_ADD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
